div_wb_ctrl: RTL and testbench
==============================

# div_wb_ctrl

Writeback arbiter and hazard guard placed directly downstream of the multi-cycle divider. It merges single-cycle EX results and divider results onto the single register-file write port, and buffers divider results that lose arbitration. It also tracks the one destination register owned by an in-flight division and raises `hold_o` to stall the pipeline on RAW/WAW hazards against that register or on a second divide issued while one is pending.

## Interface
Parameters:
- `BUF_DEPTH`, 2: divider-result buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_reg_wr_en_i`  in  1  EX-stage result write request.
- `ex_reg_wr_addr_i`  in  5  EX destination register.
- `ex_reg_wr_data_i`  in  32  EX result.
- `div_req_i`  in  1  divide issued this cycle (same pulse the divider sees).
- `div_issue_addr_i`  in  5  destination of the issued divide.
- `div_res_ready_i`  in  1  divider result pulse, 1 cycle.
- `div_res_i`  in  32  divider result, valid with the pulse.
- `div_reg_wr_addr_i`  in  5  divider destination, valid with the pulse.
- `id_rs1_addr_i`  in  5  ID source register 1.
- `id_rs2_addr_i`  in  5  ID source register 2.
- `id_div_i`  in  1  instruction in ID is DIV/DIVU/REM/REMU.
- `reg_wr_en_o`  out  1  register-file write enable, registered.
- `reg_wr_addr_o`  out  5  register-file write address, registered.
- `reg_wr_data_o`  out  32  register-file write data, registered.
- `div_pending_o`  out  1  a divide is in flight or its result is not yet written.
- `hold_o`  out  1  pipeline stall request, combinational.

## Operation
- Scoreboard: one entry, `{valid, rd}`.
  - Set on `div_req_i` with `rd = div_issue_addr_i`.
  - Cleared in the cycle the matching result is driven on `reg_wr_*`.
  - An issue with rd = x0 sets `valid` (structural hold still applies).
- `div_pending_o` = scoreboard valid OR buffer non-empty.
- `hold_o` = 1 when any of the following holds:
  - `div_pending_o` and `id_div_i` (second divide);
  - valid, rd ≠ 0, and (`id_rs1_addr_i`==rd or `id_rs2_addr_i`==rd) (RAW);
  - valid, rd ≠ 0, `ex_reg_wr_en_i`, and `ex_reg_wr_addr_i`==rd (WAW);
  - buffer full.
- Divider result pulse: push `{addr, data}` into the FIFO. A pulse when full is a protocol error; the hold rule guarantees it cannot occur.
- Arbitration each cycle, EX has strict priority:
  - `ex_reg_wr_en_i` → register the EX write;
  - else FIFO non-empty → pop the head and register it;
  - else `reg_wr_en_o` <= 0.
- Writes to x0 are forced to `reg_wr_en_o` = 0 but still pop the FIFO and clear the scoreboard.
- Divider results always commit; there is no flush or cancel.

## Timing
- Reset values: `reg_wr_en_o`=0, `reg_wr_addr_o`=0, `reg_wr_data_o`=0, `div_pending_o`=0, scoreboard invalid, FIFO empty. `hold_o` evaluates to 0.
- Reset mid-operation clears all state immediately, including a buffered result.
- Latency:
  - EX write asserted in cycle T appears on `reg_wr_*` in T+1.
  - Divider pulse at T with no EX write at T or T+1: write appears in T+1 through the FIFO bypass. A push and pop of an empty FIFO in the same cycle forwards the data directly.
  - Divider pulse at T with an EX write at T: EX write in T+1, divider write in T+2 at the earliest.
- Simultaneous push and pop when non-empty: both take effect and occupancy is unchanged.
- Pointer wrap at `BUF_DEPTH` is modulo; full/empty are tracked with an extra pointer bit.
- `div_pending_o` deasserts in the cycle after the divider result is written, and `hold_o` drops with it.
- `div_req_i` together with a scoreboard clear in the same cycle: set wins, so the new divide is tracked.

## Structure
- Constants belong in the shared `defines.v`: register-address width, data width, zero-register index.
- One sub-module: `wb_fifo`, a synchronous FIFO parameterised on depth and width (37 bits: addr + data), with same-cycle bypass when empty.
- Scoreboard, hazard logic and arbiter live in `div_wb_ctrl`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0. Release, then pulse the divider with x5=0x0000_0007 → `reg_wr_en_o`=1, addr 5, data 0x7 one cycle later.
- Collision: divider pulse (x3, 0xFFFF_FFFF) and EX write (x4, 0x1234) in the same cycle → x4/0x1234 in T+1, x3/0xFFFF_FFFF in T+2, `div_pending_o` low in T+3.
- RAW hold: divide issued to x10, then ID reads rs2=x10 → `hold_o`=1 for every cycle until x10 is written. Reading rs1=x0 after a divide to x0 → `hold_o`=0.
- Structural hold: `id_div_i`=1 while a divide is pending → `hold_o`=1. It drops the cycle after the result writes back.
- WAW: EX write to x7 while a divide to x7 is pending → `hold_o`=1. No EX write to x7 reaches the port before the divider result.
- Reset mid-flight: divide pending and FIFO holding one entry, assert `rst_n`=0 for 1 cycle → FIFO empty, `div_pending_o`=0, no stale write afterwards.

Source files
------------

// File: rtl/div_wb_ctrl_pkg.sv
// Shared widths and the writeback entry type for the divider writeback controller.
package div_wb_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/div_wb_ctrl_wb_fifo.sv
// Synchronous FIFO for divider results that lose writeback arbitration.
// When empty, a same-cycle push is visible at the head so it can be popped immediately.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             bypass;
  logic             do_write;
  logic             do_read;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign head_valid = !empty || push;
  assign head_data  = empty ? push_data : mem[rd_ptr[PTR_W-1:0]];

  assign bypass   = empty && push && pop;
  assign do_write = push && !full && !bypass;
  assign do_read  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/div_wb_ctrl.sv
// Writeback arbiter and single-entry hazard scoreboard behind the multi-cycle divider.
// EX results have priority on the register-file port; divider results queue in wb_fifo.
module div_wb_ctrl
  import div_wb_ctrl_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_reg_wr_en_i,
  input  logic [REG_ADDR_W-1:0] ex_reg_wr_addr_i,
  input  logic [DATA_W-1:0]     ex_reg_wr_data_i,
  input  logic                  div_req_i,
  input  logic [REG_ADDR_W-1:0] div_issue_addr_i,
  input  logic                  div_res_ready_i,
  input  logic [DATA_W-1:0]     div_res_i,
  input  logic [REG_ADDR_W-1:0] div_reg_wr_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_div_i,
  output logic                  reg_wr_en_o,
  output logic [REG_ADDR_W-1:0] reg_wr_addr_o,
  output logic [DATA_W-1:0]     reg_wr_data_o,
  output logic                  div_pending_o,
  output logic                  hold_o
);

  logic                  sb_valid;
  logic [REG_ADDR_W-1:0] sb_rd;
  logic                  out_is_div;

  wb_entry_t push_entry;
  wb_entry_t head_entry;
  logic      fifo_pop;
  logic      fifo_head_valid;
  logic      fifo_empty;
  logic      fifo_full;

  logic rd_live;
  logic raw_hazard;
  logic waw_hazard;
  logic ex_take;

  assign push_entry = '{addr: div_reg_wr_addr_i, data: div_res_i};

  wb_fifo #(
    .DEPTH(BUF_DEPTH),
    .WIDTH(WB_ENTRY_W)
  ) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (div_res_ready_i),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_valid(fifo_head_valid),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign rd_live    = sb_valid && !is_zero_reg(sb_rd);
  assign raw_hazard = rd_live && ((id_rs1_addr_i == sb_rd) || (id_rs2_addr_i == sb_rd));
  assign waw_hazard = rd_live && ex_reg_wr_en_i && (ex_reg_wr_addr_i == sb_rd);

  assign div_pending_o = sb_valid || !fifo_empty;
  assign hold_o        = (div_pending_o && id_div_i) || raw_hazard || waw_hazard || fifo_full;

  // A stalled EX write to the divide's destination must not overtake the older divider result.
  assign ex_take  = ex_reg_wr_en_i && !waw_hazard;
  assign fifo_pop = !ex_take && fifo_head_valid;

  // The scoreboard retires while the divider result sits on the port, so pending drops a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      reg_wr_data_o <= '0;
      out_is_div    <= 1'b0;
      sb_valid      <= 1'b0;
      sb_rd         <= '0;
    end else begin
      if (ex_take) begin
        reg_wr_en_o   <= !is_zero_reg(ex_reg_wr_addr_i);
        reg_wr_addr_o <= ex_reg_wr_addr_i;
        reg_wr_data_o <= ex_reg_wr_data_i;
        out_is_div    <= 1'b0;
      end else if (fifo_head_valid) begin
        reg_wr_en_o   <= !is_zero_reg(head_entry.addr);
        reg_wr_addr_o <= head_entry.addr;
        reg_wr_data_o <= head_entry.data;
        out_is_div    <= 1'b1;
      end else begin
        reg_wr_en_o   <= 1'b0;
        out_is_div    <= 1'b0;
      end

      if (div_req_i) begin
        sb_valid <= 1'b1;
        sb_rd    <= div_issue_addr_i;
      end else if (out_is_div) begin
        sb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_wb_ctrl.sv
// Self-checking bench for div_wb_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based model of the writeback and hazard rules.
module tb_div_wb_ctrl;

  localparam int BUF_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        ex_reg_wr_en_i;
  logic [4:0]  ex_reg_wr_addr_i;
  logic [31:0] ex_reg_wr_data_i;
  logic        div_req_i;
  logic [4:0]  div_issue_addr_i;
  logic        div_res_ready_i;
  logic [31:0] div_res_i;
  logic [4:0]  div_reg_wr_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_div_i;
  logic        reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;
  logic        div_pending_o;
  logic        hold_o;

  div_wb_ctrl #(.BUF_DEPTH(BUF_DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_reg_wr_en_i   (ex_reg_wr_en_i),
    .ex_reg_wr_addr_i (ex_reg_wr_addr_i),
    .ex_reg_wr_data_i (ex_reg_wr_data_i),
    .div_req_i        (div_req_i),
    .div_issue_addr_i (div_issue_addr_i),
    .div_res_ready_i  (div_res_ready_i),
    .div_res_i        (div_res_i),
    .div_reg_wr_addr_i(div_reg_wr_addr_i),
    .id_rs1_addr_i    (id_rs1_addr_i),
    .id_rs2_addr_i    (id_rs2_addr_i),
    .id_div_i         (id_div_i),
    .reg_wr_en_o      (reg_wr_en_o),
    .reg_wr_addr_o    (reg_wr_addr_o),
    .reg_wr_data_o    (reg_wr_data_o),
    .div_pending_o    (div_pending_o),
    .hold_o           (hold_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  // Reference state: the divide being tracked, the results waiting for the port, and the port itself.
  logic        m_valid;
  logic [4:0]  m_rd;
  wb_t         m_q[$];
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_port_is_div;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic model_pending();
    return m_valid || (m_q.size() != 0);
  endfunction

  function automatic logic model_hold();
    logic live;
    live = m_valid && (m_rd != 5'd0);
    return (model_pending() && id_div_i) ||
           (live && (id_rs1_addr_i == m_rd || id_rs2_addr_i == m_rd)) ||
           (live && ex_reg_wr_en_i && ex_reg_wr_addr_i == m_rd) ||
           (m_q.size() == BUF_DEPTH);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rd = '0; m_q.delete();
    m_en = 1'b0; m_addr = '0; m_data = '0; m_port_is_div = 1'b0;
  endtask

  // One clock edge of the reference: divider results join the back of the queue, EX goes first.
  task automatic model_step();
    logic waw;
    logic next_is_div;
    wb_t  e;
    waw = m_valid && (m_rd != 5'd0) && ex_reg_wr_en_i && (ex_reg_wr_addr_i == m_rd);
    if (div_res_ready_i) m_q.push_back('{addr: div_reg_wr_addr_i, data: div_res_i});
    next_is_div = 1'b0;
    if (ex_reg_wr_en_i && !waw) begin
      m_en = (ex_reg_wr_addr_i != 5'd0); m_addr = ex_reg_wr_addr_i; m_data = ex_reg_wr_data_i;
    end else if (m_q.size() != 0) begin
      e = m_q.pop_front();
      m_en = (e.addr != 5'd0); m_addr = e.addr; m_data = e.data;
      next_is_div = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    if (div_req_i) begin
      m_valid = 1'b1; m_rd = div_issue_addr_i;
    end else if (m_port_is_div) begin
      m_valid = 1'b0;
    end
    m_port_is_div = next_is_div;
  endtask

  task automatic clearInputs();
    ex_reg_wr_en_i = 0; ex_reg_wr_addr_i = 0; ex_reg_wr_data_i = 0;
    div_req_i = 0; div_issue_addr_i = 0;
    div_res_ready_i = 0; div_res_i = 0; div_reg_wr_addr_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_div_i = 0;
  endtask

  // Inputs are set just after a negedge; this checks the combinational outputs, clocks once,
  // and checks the registered outputs at the following negedge.
  task automatic applyStimulus();
    #1;
    checkOutput("hold", hold_o, model_hold());
    checkOutput("pending_pre", div_pending_o, model_pending());
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput("wr_en", reg_wr_en_o, m_en);
    if (m_en) begin
      checkOutput("wr_addr", reg_wr_addr_o, m_addr);
      checkOutput("wr_data", reg_wr_data_o, m_data);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    ex_reg_wr_en_i = 1'b1; ex_reg_wr_addr_i = 5'($urandom); ex_reg_wr_data_i = $urandom;
    div_req_i = 1'b1; div_issue_addr_i = 5'($urandom);
    div_res_ready_i = 1'b1; div_res_i = $urandom; div_reg_wr_addr_i = 5'($urandom);
    id_rs1_addr_i = 5'($urandom); id_rs2_addr_i = 5'($urandom); id_div_i = 1'b1;
    #2;
    model_reset();
    checkOutput("rst_en", reg_wr_en_o, 0);
    checkOutput("rst_addr", reg_wr_addr_o, 0);
    checkOutput("rst_data", reg_wr_data_o, 0);
    checkOutput("rst_pending", div_pending_o, 0);
    checkOutput("rst_hold", hold_o, 0);
    @(negedge clk);
    clearInputs();
    rst_n = 1'b1;
  endtask

  logic        busy;
  int          countdown;
  logic [4:0]  pend_addr;
  logic        seen;

  initial begin
    clearInputs();
    model_reset();
    rst_n = 1'b0;
    doReset();

    // Divider result with an empty buffer goes straight to the port.
    div_req_i = 1; div_issue_addr_i = 5'd5; applyStimulus(); clearInputs();
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd5; div_res_i = 32'h7; applyStimulus(); clearInputs();
    checkOutput("bypass_en", reg_wr_en_o, 1);
    checkOutput("bypass_addr", reg_wr_addr_o, 5);
    checkOutput("bypass_data", reg_wr_data_o, 32'h7);
    applyStimulus();
    checkOutput("bypass_retired", div_pending_o, 0);

    // Collision: EX wins, divider result follows one cycle later.
    div_req_i = 1; div_issue_addr_i = 5'd3; applyStimulus(); clearInputs();
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd3; div_res_i = 32'hFFFF_FFFF;
    ex_reg_wr_en_i = 1; ex_reg_wr_addr_i = 5'd4; ex_reg_wr_data_i = 32'h1234;
    applyStimulus(); clearInputs();
    checkOutput("coll_ex_addr", reg_wr_addr_o, 4);
    checkOutput("coll_ex_data", reg_wr_data_o, 32'h1234);
    applyStimulus();
    checkOutput("coll_div_addr", reg_wr_addr_o, 3);
    checkOutput("coll_div_data", reg_wr_data_o, 32'hFFFF_FFFF);
    checkOutput("coll_pending_t2", div_pending_o, 1);
    applyStimulus();
    checkOutput("coll_pending_t3", div_pending_o, 0);

    // RAW against x10 until it is written; a divide to x0 never causes a RAW stall.
    div_req_i = 1; div_issue_addr_i = 5'd10; applyStimulus(); clearInputs();
    id_rs2_addr_i = 5'd10;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("raw_hold", hold_o, 1);
      applyStimulus();
    end
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd10; div_res_i = 32'hCAFE; applyStimulus();
    div_res_ready_i = 0; applyStimulus();
    applyStimulus();
    #1 checkOutput("raw_released", hold_o, 0);
    clearInputs();
    div_req_i = 1; div_issue_addr_i = 5'd0; applyStimulus(); clearInputs();
    id_rs1_addr_i = 5'd0;
    #1 checkOutput("x0_no_raw", hold_o, 0);
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd0; div_res_i = 32'hBEEF; applyStimulus(); clearInputs();
    checkOutput("x0_no_write", reg_wr_en_o, 0);
    applyStimulus();

    // Structural hold on a second divide drops the cycle after writeback.
    div_req_i = 1; div_issue_addr_i = 5'd8; applyStimulus(); clearInputs();
    id_div_i = 1;
    #1 checkOutput("struct_hold", hold_o, 1);
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd8; div_res_i = 32'h88; applyStimulus();
    div_res_ready_i = 0;
    #1 checkOutput("struct_hold_wb", hold_o, 1);
    applyStimulus();
    #1 checkOutput("struct_drop", hold_o, 0);
    clearInputs();

    // WAW: the stalled EX write to x7 must land after the divider result.
    div_req_i = 1; div_issue_addr_i = 5'd7; applyStimulus(); clearInputs();
    ex_reg_wr_en_i = 1; ex_reg_wr_addr_i = 5'd7; ex_reg_wr_data_i = 32'hAAAA;
    #1 checkOutput("waw_hold", hold_o, 1);
    applyStimulus();
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd7; div_res_i = 32'h5555;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      div_res_ready_i = 0;
      if (!seen && reg_wr_en_o && reg_wr_addr_o == 5'd7) begin
        seen = 1'b1;
        checkOutput("waw_order", reg_wr_data_o, 32'h5555);
      end
    end
    checkOutput("waw_written", seen, 1);
    clearInputs();
    applyStimulus();

    // Reset with a divide tracked and one result parked in the buffer.
    div_req_i = 1; div_issue_addr_i = 5'd9; applyStimulus(); clearInputs();
    div_res_ready_i = 1; div_reg_wr_addr_i = 5'd9; div_res_i = 32'h99;
    ex_reg_wr_en_i = 1; ex_reg_wr_addr_i = 5'd2; ex_reg_wr_data_i = 32'h22;
    applyStimulus(); clearInputs();
    checkOutput("mid_pending", div_pending_o, 1);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("mid_no_stale", reg_wr_en_o, 0);

    // Randomized traffic with a single divide in flight at a time.
    busy = 1'b0; countdown = 0; pend_addr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clearInputs();
      ex_reg_wr_en_i   = 1'($urandom);
      ex_reg_wr_addr_i = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom);
      ex_reg_wr_data_i = $urandom;
      id_rs1_addr_i    = ($urandom_range(0, 3) == 0) ? m_rd : 5'($urandom);
      id_rs2_addr_i    = 5'($urandom);
      id_div_i         = 1'($urandom);
      if (busy) begin
        if (countdown == 0) begin
          div_res_ready_i = 1; div_reg_wr_addr_i = pend_addr; div_res_i = $urandom;
          busy = 1'b0;
        end else begin
          countdown--;
        end
      end else if (m_q.size() == 0 && (!m_valid || m_port_is_div) && $urandom_range(0, 2) == 0) begin
        div_req_i = 1; div_issue_addr_i = 5'($urandom);
        pend_addr = div_issue_addr_i; busy = 1'b1; countdown = $urandom_range(0, 5);
      end
      applyStimulus();
      checkOutput("rand_pending", div_pending_o, model_pending());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
